// File: rtl/positaccum_feed_es3_pkg.sv
// Shared widths, defaults and FSM encoding for the es3 posit accumulator feeder.
// Serialized posit layout, MSB first: sgn, scale[8:0], fraction[251:0], inf, zero.
package posit_defines_es3;

   localparam int POSIT_SERIALIZED_WIDTH_ACCUM_ES3 = 264;
   localparam int POSIT_SCALE_WIDTH               = 9;
   localparam int ACC_LATENCY_DEFAULT             = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD,
      ST_OUTPUT
   } feed_state_t;

   typedef struct packed {
      logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES3-1:0] data;
      logic                                        last;
   } feed_entry_t;

endpackage

// File: rtl/positaccum_feed_es3_fifo.sv
// Generic synchronous FIFO, combinational head read, zero-latency pop.
// Callers gate push with !full and pop with !empty; illegal requests are dropped.
module posit_fifo_es3 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/positaccum_feed_es3.sv
// Feeds buffered posit elements one at a time into a fixed-latency accumulator and emits each vector sum.
// Sum appears CLEAR + n*(ACC_LATENCY+1) + 1 cycles after start; upstream stalls via in_ready when the buffer is full.
module positaccum_feed_es3
   import posit_defines_es3::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int ACC_LATENCY = ACC_LATENCY_DEFAULT
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES3-1:0] in_data,
   input  logic                                        in_last,
   output logic                                        acc_rst,
   output logic                                        acc_start,
   output logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES3-1:0] acc_in1,
   input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES3-1:0] acc_result,
   input  logic                                        acc_done,
   input  logic                                        acc_truncated,
   output logic                                        out_valid,
   output logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES3-1:0] out_data,
   output logic                                        out_truncated,
   output logic                                        err_timeout
);

   localparam int CW = $clog2(ACC_LATENCY + 5);
   // Counter reads k in the k-th cycle after ISSUE; the flag is visible ACC_LATENCY+4 cycles after ISSUE.
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(ACC_LATENCY + 3);

   feed_state_t state, state_n;
   feed_entry_t push_entry;
   feed_entry_t head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;

   logic [CW-1:0]                               wait_cnt;
   logic                                        cur_last;
   logic                                        trunc_sticky;
   logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES3-1:0] result_q;
   logic                                        wait_done;
   logic                                        done_trunc;

   assign push_entry = '{data: in_data, last: in_last};
   assign in_ready   = !fifo_full;
   assign fifo_push  = in_valid && in_ready;

   posit_fifo_es3 #(
      .WIDTH ($bits(feed_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A missing acc_done is treated as a done that lost precision.
   assign wait_done  = (state == ST_WAIT) && (acc_done || (wait_cnt == TIMEOUT_CNT));
   assign done_trunc = acc_done ? acc_truncated : 1'b1;

   assign acc_rst       = rst || (state == ST_CLEAR);
   assign out_valid     = !rst && (state == ST_OUTPUT);
   assign out_data      = out_valid ? result_q : '0;
   assign out_truncated = out_valid && trunc_sticky;

   always_comb begin
      state_n   = state;
      fifo_pop  = 1'b0;
      acc_start = 1'b0;
      acc_in1   = '0;
      if (!rst) begin
         case (state)
            ST_IDLE:   if (!fifo_empty) state_n = ST_CLEAR;
            ST_CLEAR:  state_n = ST_ISSUE;
            ST_ISSUE: begin
               acc_start = 1'b1;
               acc_in1   = head.data;
               fifo_pop  = 1'b1;
               state_n   = ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_done) begin
                  if (cur_last)         state_n = ST_OUTPUT;
                  else if (!fifo_empty) state_n = ST_ISSUE;
                  else                  state_n = ST_HOLD;
               end
            end
            ST_HOLD:   if (!fifo_empty) state_n = ST_ISSUE;
            ST_OUTPUT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         cur_last     <= 1'b0;
         trunc_sticky <= 1'b0;
         result_q     <= '0;
         err_timeout  <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            ST_CLEAR: trunc_sticky <= 1'b0;
            ST_ISSUE: begin
               cur_last <= head.last;
               wait_cnt <= CW'(1);
            end
            ST_WAIT: begin
               if (wait_done) begin
                  trunc_sticky <= trunc_sticky || done_trunc;
                  result_q     <= acc_result;
                  if (!acc_done) err_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/positaccum_feed_es3.md
POSITACCUM_FEED_ES3 -- requirements
Module: positaccum_feed_es3

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: input buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter ACC_LATENCY, default 16: cycles from acc_start to acc_done in the downstream accumulator.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid/in_ready  input/output  1/1  upstream valid/ready handshake.
REQ-006 SHALL have port in_data  input  W  serialized posit value {sgn, scale[8:0], fraction, inf, zero}, where W = POSIT_SERIALIZED_WIDTH_ACCUM_ES3 (264).
REQ-007 SHALL have port in_last  input  1  marks the final element of a dot-product vector.
REQ-008 SHALL have ports acc_rst, acc_start, acc_in1  output  1, 1, W  drive the accumulator's rst, start and in1.
REQ-009 SHALL have ports acc_result, acc_done, acc_truncated  input  W, 1, 1  accumulator outputs.
REQ-010 SHALL have ports out_valid, out_data, out_truncated  output  1, W, 1  final vector sum, one-cycle pulse.
REQ-011 SHALL have port err_timeout  output  1  sticky flag: acc_done was missed.

Function
REQ-012 SHALL buffer inputs in a FIFO; in_ready = not full; push on in_valid & in_ready; {in_data, in_last} stored together.
REQ-013 SHALL run FSM states IDLE, CLEAR, ISSUE, WAIT, HOLD, OUTPUT.
REQ-014 IDLE: if FIFO non-empty -> CLEAR.
REQ-015 CLEAR: acc_rst=1 for exactly 1 cycle; clears truncation sticky; -> ISSUE.
REQ-016 ISSUE: acc_start=1 and acc_in1=FIFO head for exactly 1 cycle; pop head; latch head's last flag; load wait counter; -> WAIT.
REQ-017 Outside ISSUE, acc_start=0 and acc_in1=0, so the accumulator injects zero; at most one element is in flight.
REQ-018 WAIT: on acc_done, OR acc_truncated into the truncation sticky; then last flag=1 -> OUTPUT, otherwise -> ISSUE if FIFO non-empty, else HOLD.
REQ-019 HOLD: vector open, waiting for data; FIFO non-empty -> ISSUE; acc_rst is not pulsed.
REQ-020 OUTPUT: out_valid=1 for 1 cycle; out_data=acc_result captured on the acc_done cycle; out_truncated=sticky; -> IDLE.
REQ-021 Wait counter SHALL count cycles since ISSUE; reaching ACC_LATENCY+4 without acc_done sets err_timeout and acts as a done with acc_truncated=1.
REQ-022 acc_done outside WAIT SHALL be ignored.
REQ-023 Push and pop in the same cycle SHALL be allowed when full or empty (empty: only the push takes effect; full: in_ready=0 so no push).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-025 Best-case throughput SHALL be one element per ACC_LATENCY+1 cycles; vector latency = CLEAR + n*(ACC_LATENCY+1) + 1 cycles.

Reset
REQ-026 On rst: FSM=IDLE, FIFO empty, in_ready=1, acc_start=0, acc_in1=0, out_valid=0, out_data=0, out_truncated=0, err_timeout=0.
REQ-027 acc_rst SHALL be asserted while rst=1, so a mid-vector reset also clears the accumulator.
REQ-028 A reset mid-vector SHALL discard buffered elements and the in-flight element, with no out_valid.

Structure
REQ-029 W, ACC_LATENCY default and the FSM state enum SHALL live in package posit_defines_es3.
REQ-030 The FIFO SHALL be a sub-module posit_fifo_es3 (parameters WIDTH, DEPTH).

Verification
REQ-031 Push 1.0 (sgn0, scale0, frac0) and 1.0 with last -> one out_valid, out_data scale=1, frac=0, zero=0, out_truncated=0.
REQ-032 Push +3.0 and -3.0 with last -> out_data zero=1.
REQ-033 Push 1.0 with scale=0 and 1.0 with scale=-100, last -> out_truncated=1.
REQ-034 Push FIFO_DEPTH+4 elements back-to-back -> in_ready drops at full; every element issued in order; acc_start never closer than ACC_LATENCY+1 cycles apart.
REQ-035 Accumulator model withholds acc_done -> err_timeout=1 at ISSUE+ACC_LATENCY+4; the FSM proceeds.
REQ-036 Assert rst during WAIT of a 4-element vector -> no out_valid; next vector 2.0+2.0 -> result 4.0 (scale2, frac0).
